// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by the pipeline registers and decoder.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, in-order responses buffered
// in a 2-entry FIFO toward the decoder, redirect kills any in-flight response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = INSTR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready
);

  localparam int unsigned ENTRY_W = INSTR_WIDTH + ADDR_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [ENTRY_W-1:0]    head;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue only when the slot freed this cycle (if any) plus the FIFO leave room for one more word.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      IDLE:    mem_req_valid = !full;
      WAIT:    mem_req_valid = mem_resp_valid && empty;
      DROP:    mem_req_valid = mem_resp_valid && !full;
      default: mem_req_valid = 1'b0;
    endcase
    if (!rst_n || redirect_valid) mem_req_valid = 1'b0;
    req_fire = mem_req_valid && mem_req_ready;

    unique case (state_q)
      IDLE: if (req_fire) state_d = WAIT;
      WAIT: begin
        if (redirect_valid)      state_d = mem_resp_valid ? IDLE : DROP;
        else if (mem_resp_valid) state_d = req_fire ? WAIT : IDLE;
        push = mem_resp_valid && !redirect_valid;
      end
      DROP: if (mem_resp_valid) state_d = req_fire ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(PC_INC);
      req_pc_q   <= fetch_pc_q;
    end
  end

  assign pop          = !empty && instr_ready && !redirect_valid;
  assign mem_req_addr = fetch_pc_q;

  fetch_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({mem_resp_data, req_pc_q}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign instr_valid = !empty;
  assign instr       = head[ENTRY_W-1 -: INSTR_WIDTH];
  assign instr_pc    = head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a driver/memory model issues
// expectations, a separate monitor compares and owns the expected queue.
module tb_fetch_unit;

  localparam int unsigned AW  = 64;
  localparam int unsigned IW  = 32;
  localparam logic [AW-1:0] RPC = 64'h1000;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic          clk;
  logic          rst_n;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [IW-1:0] mem_resp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  fetch_unit #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  entry_t      exp_q[$];
  int          passed;
  int          total;

  // Memory / program model state (driver only)
  bit          outstanding, killed, rst_seen, last_rst_low;
  logic [AW-1:0] out_addr, model_pc;
  int          lat_cnt;

  int unsigned p_ready, p_iready, p_redir, lat_min, lat_max;
  bit          force_redir, rst_val;
  logic [AW-1:0] force_pc;

  // Per-cycle expectations handed from driver to monitor
  bit          ev_live, ev_req_exp, ev_after_rst, ev_push, ev_flush, ev_bad;
  logic [AW-1:0] ev_pc;
  entry_t      ev_entry;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    logic [AW-1:0] h;
    h = a * 64'h9E37_79B9_7F4A_7C15;
    return h[AW-1:AW-IW] ^ a[IW-1:0];
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  // One clock cycle: drive inputs at negedge, then work out what the next edge must do.
  task automatic step();
    bit            resp;
    logic [AW-1:0] rpc;
    @(negedge clk);
    rst_n          = rst_val;
    resp           = rst_val && outstanding && (lat_cnt == 0);
    mem_resp_valid = resp;
    mem_resp_data  = resp ? word_of(out_addr) : IW'($urandom);
    rpc            = {$urandom, $urandom};
    if ($urandom_range(1) == 1) rpc[AW-1:20] = '0;
    redirect_valid = rst_val && (force_redir || ($urandom_range(99) < p_redir));
    redirect_pc    = force_redir ? force_pc : rpc;
    force_redir    = 1'b0;
    mem_req_ready  = $urandom_range(99) < p_ready;
    instr_ready    = $urandom_range(99) < p_iready;
    #1;
    ev_live      = rst_seen;
    ev_after_rst = last_rst_low;
    ev_req_exp   = rst_val && !redirect_valid && (!outstanding || resp) &&
                   ((exp_q.size() + ((resp && !killed) ? 1 : 0)) < 2);
    ev_pc        = model_pc;
    ev_push      = 1'b0;
    ev_flush     = 1'b0;
    if (!rst_val) begin
      ev_flush    = 1'b1;
      outstanding = 1'b0;
      killed      = 1'b0;
      model_pc    = RPC;
    end else begin
      if (resp) begin
        outstanding = 1'b0;
        if (!killed && !redirect_valid) begin
          ev_push  = 1'b1;
          ev_entry = '{instr: word_of(out_addr), pc: out_addr};
        end
      end else if (outstanding) begin
        lat_cnt--;
      end
      if (redirect_valid) begin
        ev_flush = 1'b1;
        if (outstanding) killed = 1'b1;
        model_pc = {redirect_pc[AW-1:2], 2'b00};
      end else if (mem_req_valid && mem_req_ready) begin
        outstanding = 1'b1;
        killed      = 1'b0;
        out_addr    = model_pc;
        lat_cnt     = int'($urandom_range(lat_max, lat_min));
        model_pc    = model_pc + 64'd4;
      end
    end
    if (!rst_val) rst_seen = 1'b1;
    last_rst_low = !rst_val;
  endtask

  // Monitor: compares DUT outputs, pops on decoder handshake, then applies this cycle's model updates.
  always @(negedge clk) begin
    #3;
    if (ev_bad) begin
      total++;
      $display("FAIL setup_bound: got no WAIT on 1004, expected WAIT on 1004");
    end
    if (ev_live) begin
      check("req_valid", 64'(mem_req_valid), 64'(ev_req_exp));
      if (mem_req_valid) check("req_addr", mem_req_addr, ev_pc);
      check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
      if (ev_after_rst) begin
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_req_addr", mem_req_addr, RPC);
      end
      if (instr_valid && exp_q.size() != 0) begin
        check("instr", 64'(instr), 64'(exp_q[0].instr));
        check("instr_pc", instr_pc, exp_q[0].pc);
        if (instr_ready && !redirect_valid && rst_n) void'(exp_q.pop_front());
      end
    end
    if (ev_flush) exp_q.delete();
    if (ev_push) exp_q.push_back(ev_entry);
  end

  task automatic do_reset(input int cycles);
    rst_val = 1'b0;
    repeat (cycles) step();
    rst_val = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    outstanding = 1'b0; killed = 1'b0; rst_seen = 1'b0; last_rst_low = 1'b0;
    out_addr = '0; model_pc = RPC; lat_cnt = 0;
    force_redir = 1'b0; force_pc = '0; rst_val = 1'b0;
    ev_live = 1'b0; ev_req_exp = 1'b0; ev_after_rst = 1'b0; ev_push = 1'b0;
    ev_flush = 1'b0; ev_bad = 1'b0; ev_pc = '0; ev_entry = '0;

    // Streaming from RESET_PC, 1-cycle memory, decoder always ready
    p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 0; lat_max = 0;
    do_reset(2);
    repeat (20) step();

    // Decoder stall fills the FIFO, then drains in order
    p_iready = 0;
    repeat (12) step();
    p_iready = 100;
    repeat (6) step();

    // Redirect to 0x2003 while waiting on the 0x1004 response
    lat_min = 2; lat_max = 2;
    do_reset(1);
    for (int i = 0; i < 40 && !(outstanding && !killed && out_addr == 64'h1004); i++) step();
    if (!(outstanding && out_addr == 64'h1004)) ev_bad = 1'b1;
    force_redir = 1'b1; force_pc = 64'h2003;
    step();
    ev_bad = 1'b0;
    repeat (12) step();

    // Memory back-pressure holds the request address
    p_ready = 0;
    repeat (6) step();
    p_ready = 100;
    repeat (4) step();

    // PC wrap at the top of the address space
    lat_min = 0; lat_max = 0;
    force_redir = 1'b1; force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    repeat (8) step();

    // Reset while waiting with one word buffered
    lat_min = 2; lat_max = 2; p_iready = 0;
    do_reset(1);
    repeat (5) step();
    do_reset(1);
    repeat (6) step();

    // Randomized traffic with a mid-run reset
    p_ready = 70; p_iready = 70; p_redir = 4; lat_min = 0; lat_max = 3;
    repeat (1500) step();
    do_reset(1);
    p_ready = 50; p_iready = 40; p_redir = 2; lat_max = 1;
    repeat (1500) step();

    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 64, PC and address width; INSTR_WIDTH, default 32, instruction width; RESET_PC, default 0, first fetch address.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 mem_req_valid  output  1  an instruction-memory read request is presented.
REQ-005 mem_req_addr  output  ADDR_WIDTH  request address, 4-byte aligned.
REQ-006 mem_req_ready  input  1  memory accepts the request in this cycle.
REQ-007 mem_resp_valid  input  1  read data returned, in order, for the oldest accepted request.
REQ-008 mem_resp_data  input  INSTR_WIDTH  returned instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute.
REQ-010 redirect_pc  input  ADDR_WIDTH  redirect target.
REQ-011 instr_valid  output  1  instr and instr_pc are valid for the decoder.
REQ-012 instr  output  INSTR_WIDTH  instruction word driven to the decoder instr input.
REQ-013 instr_pc  output  ADDR_WIDTH  address of instr.
REQ-014 instr_ready  input  1  decoder consumes the instruction in this cycle.

Function
REQ-015 Request handshake: a request SHALL transfer when mem_req_valid && mem_req_ready; mem_req_addr SHALL be held stable while mem_req_valid=1 and not ready, unless a redirect occurs.
REQ-016 At most one request SHALL be outstanding; FSM states: IDLE (no request outstanding), WAIT (response pending), DROP (response pending that must be discarded).
REQ-017 IDLE->WAIT on request transfer; WAIT->IDLE on mem_resp_valid; WAIT->DROP on redirect_valid; DROP->IDLE on mem_resp_valid; DROP->WAIT on mem_resp_valid coincident with a new request transfer.
REQ-018 mem_req_valid SHALL be 1 only in IDLE (or in DROP/WAIT in the cycle the response returns), with no redirect that cycle, and only when queue occupancy plus outstanding count is less than 2.
REQ-019 fetch_pc SHALL advance by 4 (modulo 2^ADDR_WIDTH, wrapping at all-ones) on each request transfer.
REQ-020 A 2-entry FIFO SHALL hold {instr, pc} pairs; a response in WAIT SHALL be written to it with the pc of its request; a response in DROP SHALL be discarded.
REQ-021 instr_valid SHALL equal FIFO non-empty; instr/instr_pc SHALL be the head entry; the head SHALL pop on instr_valid && instr_ready.
REQ-022 Latency: a response accepted in cycle N SHALL appear at instr_valid in cycle N+1; back-to-back accepted requests SHALL be issued no faster than one per response.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged; a response SHALL never arrive when the FIFO is full (guaranteed by REQ-018).
REQ-024 Redirect SHALL have priority over all other events in its cycle: flush the FIFO (instr_valid=0 next cycle), set fetch_pc to {redirect_pc[ADDR_WIDTH-1:2],2'b00}, suppress mem_req_valid that cycle, and ignore a coincident pop or response write.
REQ-025 A redirect arriving in DROP SHALL only update fetch_pc; a redirect in IDLE SHALL only update fetch_pc and flush.
REQ-026 mem_resp_valid in IDLE SHALL be ignored.

Reset
REQ-027 On rst_n=0 at a clock edge: state=IDLE, fetch_pc=RESET_PC, FIFO empty; outputs mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, mem_req_addr=RESET_PC.
REQ-028 Reset mid-request SHALL abandon the outstanding request; the first post-reset request SHALL issue in the first cycle with rst_n=1.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, WAIT, DROP), the instruction width and PC increment constant 4, for reuse by the pipeline registers and decoder.
REQ-030 The FIFO SHALL be one sub-module, fetch_fifo (parameterised width, depth 2, push/pop/flush, full/empty).

Verification
REQ-031 Reset release, RESET_PC=0x1000, memory 1-cycle latency, instr_ready=1 -> requests at 0x1000,0x1004,0x1008; instr_pc sequence matches and each instr equals the returned data.
REQ-032 instr_ready=0 for 10 cycles -> FIFO fills to 2, mem_req_valid stays 0, no entry lost; on release, order is preserved.
REQ-033 Redirect to 0x2003 while in WAIT for 0x1004 -> the 0x1004 response is dropped, the next request is 0x2000, and instr_valid=0 until the 0x2000 data returns.
REQ-034 mem_req_ready=0 for 5 cycles -> mem_req_addr is held constant and fetch_pc does not advance.
REQ-035 fetch_pc=0xFFFF_FFFF_FFFF_FFFC -> next request address is 0x0.
REQ-036 Assert rst_n=0 during WAIT with the FIFO holding 1 entry -> the next cycle shows instr_valid=0 and a request at RESET_PC once rst_n=1.
